// File: rtl/display_edit_controller_pkg.sv
// Shared view codes, field indices and button decoding for the display edit controller.
package calendar_ui_pkg;

    localparam logic [2:0] MODE_CLOCK = 3'd0;
    localparam logic [2:0] MODE_DATE  = 3'd1;
    localparam logic [2:0] MODE_DCAL  = 3'd2;

    localparam int NUM_FIELDS = 13;

    localparam logic [3:0] SEL_SEC           = 4'd0;
    localparam logic [3:0] SEL_MIN           = 4'd1;
    localparam logic [3:0] SEL_HOUR          = 4'd2;
    localparam logic [3:0] SEL_DAY           = 4'd3;
    localparam logic [3:0] SEL_MONTH         = 4'd4;
    localparam logic [3:0] SEL_YEAR_LO       = 4'd5;
    localparam logic [3:0] SEL_YEAR_HUN      = 4'd6;
    localparam logic [3:0] SEL_YEAR_HI       = 4'd7;
    localparam logic [3:0] SEL_DSET_DAY      = 4'd8;
    localparam logic [3:0] SEL_DSET_MONTH    = 4'd9;
    localparam logic [3:0] SEL_DSET_YEAR_LO  = 4'd10;
    localparam logic [3:0] SEL_DSET_YEAR_HUN = 4'd11;
    localparam logic [3:0] SEL_DSET_YEAR_HI  = 4'd12;

    localparam logic [3:0] FIRST_CLOCK = SEL_HOUR;
    localparam logic [3:0] LAST_CLOCK  = SEL_SEC;
    localparam logic [3:0] FIRST_DATE  = SEL_YEAR_HI;
    localparam logic [3:0] LAST_DATE   = SEL_DAY;
    localparam logic [3:0] FIRST_DCAL  = SEL_DSET_YEAR_HI;
    localparam logic [3:0] LAST_DCAL   = SEL_DSET_DAY;

    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_SET,
        ACT_NEXT,
        ACT_UP,
        ACT_DOWN,
        ACT_MODE
    } btn_action_t;

    // Only the highest-priority button of a cycle survives.
    function automatic btn_action_t encode_buttons(
        input logic set,
        input logic next,
        input logic up,
        input logic down,
        input logic mode
    );
        if (set)       return ACT_SET;
        else if (next) return ACT_NEXT;
        else if (up)   return ACT_UP;
        else if (down) return ACT_DOWN;
        else if (mode) return ACT_MODE;
        else           return ACT_NONE;
    endfunction

    function automatic logic [2:0] next_mode(input logic [2:0] m);
        case (m)
            MODE_CLOCK: return MODE_DATE;
            MODE_DATE:  return MODE_DCAL;
            default:    return MODE_CLOCK;
        endcase
    endfunction

    function automatic logic [3:0] first_field(input logic [2:0] m);
        case (m)
            MODE_DATE: return FIRST_DATE;
            MODE_DCAL: return FIRST_DCAL;
            default:   return FIRST_CLOCK;
        endcase
    endfunction

    function automatic logic [3:0] last_field(input logic [2:0] m);
        case (m)
            MODE_DATE: return LAST_DATE;
            MODE_DCAL: return LAST_DCAL;
            default:   return LAST_CLOCK;
        endcase
    endfunction

    // Last fields of each view map to themselves; the caller exits edit there instead.
    function automatic logic [3:0] next_field(input logic [3:0] f);
        case (f)
            SEL_HOUR:          return SEL_MIN;
            SEL_MIN:           return SEL_SEC;
            SEL_YEAR_HI:       return SEL_YEAR_HUN;
            SEL_YEAR_HUN:      return SEL_YEAR_LO;
            SEL_YEAR_LO:       return SEL_MONTH;
            SEL_MONTH:         return SEL_DAY;
            SEL_DSET_YEAR_HI:  return SEL_DSET_YEAR_HUN;
            SEL_DSET_YEAR_HUN: return SEL_DSET_YEAR_LO;
            SEL_DSET_YEAR_LO:  return SEL_DSET_MONTH;
            SEL_DSET_MONTH:    return SEL_DSET_DAY;
            default:           return f;
        endcase
    endfunction

    function automatic logic [NUM_FIELDS-1:0] field_onehot(input logic [3:0] f);
        return {{(NUM_FIELDS-1){1'b0}}, 1'b1} << f;
    endfunction

endpackage

// File: rtl/display_edit_controller_if.sv
// Button pulses in, view/edit control out, between the debouncers and the display/counter registers.
interface display_edit_if;

    logic        tick_1hz;
    logic        btn_mode;
    logic        btn_set;
    logic        btn_next;
    logic        btn_up;
    logic        btn_down;

    logic [2:0]  mode;
    logic        set_dday;
    logic [12:0] select;
    logic        edit_active;
    logic [3:0]  field_id;
    logic        inc;
    logic        dec;
    logic        commit;
    logic        abort;

    modport master (
        output tick_1hz, btn_mode, btn_set, btn_next, btn_up, btn_down,
        input  mode, set_dday, select, edit_active, field_id, inc, dec, commit, abort
    );

    modport slave (
        input  tick_1hz, btn_mode, btn_set, btn_next, btn_up, btn_down,
        output mode, set_dday, select, edit_active, field_id, inc, dec, commit, abort
    );

endinterface

// File: rtl/display_edit_controller_timeout.sv
// Seconds-of-inactivity counter for edit mode; expire fires on the tick that reaches TIMEOUT_S.
module edit_timeout_counter #(
    parameter int TIMEOUT_S = 30
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic tick,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT_S > 1) ? $clog2(TIMEOUT_S) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_S - 1);

    logic [CNT_W-1:0] count;

    // Holds at LAST rather than wrapping, so a missed exit can never restart the window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (tick && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    assign expire = tick && !clear && (count == LAST);

endmodule

// File: rtl/display_edit_controller.sv
// Turns debounced button pulses into view mode, field-edit navigation and inc/dec/commit/abort pulses.
module display_edit_controller
    import calendar_ui_pkg::*;
#(
    parameter int TIMEOUT_S = 30
) (
    input  logic          clk,
    input  logic          rst_n,
    display_edit_if.slave ui
);

    localparam logic [0:0] ST_VIEW = 1'b0;
    localparam logic [0:0] ST_EDIT = 1'b1;

    logic [0:0]            state, state_nxt;
    logic [2:0]            mode_q, mode_nxt;
    logic [3:0]            field_q, field_nxt;
    logic [NUM_FIELDS-1:0] select_q;
    logic                  set_dday_q, set_dday_nxt;
    logic                  inc_q, inc_nxt;
    logic                  dec_q, dec_nxt;
    logic                  commit_q, commit_nxt;
    logic                  abort_q, abort_nxt;
    logic                  exit_edit;
    logic                  tmo_clear;
    logic                  expire;
    btn_action_t           action;

    assign action = encode_buttons(ui.btn_set, ui.btn_next, ui.btn_up,
                                   ui.btn_down, ui.btn_mode);

    // Any accepted edit button restarts the inactivity window; btn_mode in edit does not.
    assign tmo_clear = (state != ST_EDIT) ||
                       (action == ACT_SET) || (action == ACT_NEXT) ||
                       (action == ACT_UP)  || (action == ACT_DOWN);

    edit_timeout_counter #(
        .TIMEOUT_S (TIMEOUT_S)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (tmo_clear),
        .tick   (ui.tick_1hz),
        .expire (expire)
    );

    always_comb begin
        state_nxt    = state;
        mode_nxt     = mode_q;
        field_nxt    = field_q;
        set_dday_nxt = set_dday_q;
        inc_nxt      = 1'b0;
        dec_nxt      = 1'b0;
        commit_nxt   = 1'b0;
        abort_nxt    = 1'b0;
        exit_edit    = 1'b0;

        if (state == ST_VIEW) begin
            if (action == ACT_SET) begin
                state_nxt    = ST_EDIT;
                field_nxt    = first_field(mode_q);
                set_dday_nxt = (mode_q == MODE_DCAL);
            end else if (action == ACT_MODE) begin
                mode_nxt = next_mode(mode_q);
            end
        end else begin
            case (action)
                ACT_SET: begin
                    exit_edit  = 1'b1;
                    commit_nxt = 1'b1;
                end
                ACT_NEXT: begin
                    if (field_q == last_field(mode_q)) begin
                        exit_edit  = 1'b1;
                        commit_nxt = 1'b1;
                    end else begin
                        field_nxt = next_field(field_q);
                    end
                end
                ACT_UP:   inc_nxt = 1'b1;
                ACT_DOWN: dec_nxt = 1'b1;
                default: begin
                    if (expire) begin
                        exit_edit = 1'b1;
                        abort_nxt = 1'b1;
                    end
                end
            endcase
        end

        if (exit_edit) begin
            state_nxt    = ST_VIEW;
            field_nxt    = '0;
            set_dday_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_VIEW;
            mode_q     <= MODE_CLOCK;
            field_q    <= '0;
            select_q   <= '0;
            set_dday_q <= 1'b0;
            inc_q      <= 1'b0;
            dec_q      <= 1'b0;
            commit_q   <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state      <= state_nxt;
            mode_q     <= mode_nxt;
            field_q    <= field_nxt;
            select_q   <= (state_nxt == ST_EDIT) ? field_onehot(field_nxt) : '0;
            set_dday_q <= set_dday_nxt;
            inc_q      <= inc_nxt;
            dec_q      <= dec_nxt;
            commit_q   <= commit_nxt;
            abort_q    <= abort_nxt;
        end
    end

    assign ui.mode        = mode_q;
    assign ui.set_dday    = set_dday_q;
    assign ui.select      = select_q;
    assign ui.edit_active = (state == ST_EDIT);
    assign ui.field_id    = field_q;
    assign ui.inc         = inc_q;
    assign ui.dec         = dec_q;
    assign ui.commit      = commit_q;
    assign ui.abort       = abort_q;

endmodule

// File: tb/tb_display_edit_controller.sv
// Directed scoreboard bench for display_edit_controller with a short timeout.
module tb_display_edit_controller;

    localparam int TIMEOUT_S = 3;

    localparam logic [4:0] B_NONE = 5'b00000;
    localparam logic [4:0] B_SET  = 5'b00001;
    localparam logic [4:0] B_NEXT = 5'b00010;
    localparam logic [4:0] B_UP   = 5'b00100;
    localparam logic [4:0] B_DOWN = 5'b01000;
    localparam logic [4:0] B_MODE = 5'b10000;

    localparam logic [3:0] P_NONE   = 4'b0000;
    localparam logic [3:0] P_INC    = 4'b1000;
    localparam logic [3:0] P_DEC    = 4'b0100;
    localparam logic [3:0] P_COMMIT = 4'b0010;
    localparam logic [3:0] P_ABORT  = 4'b0001;

    typedef struct packed {
        logic [2:0]  mode;
        logic        set_dday;
        logic [12:0] select;
        logic        edit_active;
        logic [3:0]  field_id;
        logic        inc;
        logic        dec;
        logic        commit;
        logic        abort;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t sb[$];

    display_edit_if ui ();

    display_edit_controller #(
        .TIMEOUT_S (TIMEOUT_S)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ui    (ui)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t view_exp(input logic [2:0] m);
        exp_t e;
        e      = '0;
        e.mode = m;
        return e;
    endfunction

    function automatic exp_t edit_exp(input logic [2:0] m, input logic [12:0] sel,
                                      input logic [3:0] fid);
        exp_t e;
        e             = '0;
        e.mode        = m;
        e.set_dday    = (m == 3'd2);
        e.select      = sel;
        e.edit_active = 1'b1;
        e.field_id    = fid;
        return e;
    endfunction

    function automatic exp_t pulse(input exp_t base, input logic [3:0] p);
        exp_t e;
        e        = base;
        e.inc    = p[3];
        e.dec    = p[2];
        e.commit = p[1];
        e.abort  = p[0];
        return e;
    endfunction

    task automatic compare(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_output(input string step);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL %s: scoreboard empty, observed output has no expected entry", step);
        end else begin
            e = sb.pop_front();
            compare({step, ".mode"},        16'(ui.mode),        16'(e.mode));
            compare({step, ".set_dday"},    16'(ui.set_dday),    16'(e.set_dday));
            compare({step, ".select"},      16'(ui.select),      16'(e.select));
            compare({step, ".edit_active"}, 16'(ui.edit_active), 16'(e.edit_active));
            compare({step, ".field_id"},    16'(ui.field_id),    16'(e.field_id));
            compare({step, ".inc"},         16'(ui.inc),         16'(e.inc));
            compare({step, ".dec"},         16'(ui.dec),         16'(e.dec));
            compare({step, ".commit"},      16'(ui.commit),      16'(e.commit));
            compare({step, ".abort"},       16'(ui.abort),       16'(e.abort));
        end
    endtask

    task automatic drive(input logic [4:0] btn, input logic tick);
        ui.btn_set  = btn[0];
        ui.btn_next = btn[1];
        ui.btn_up   = btn[2];
        ui.btn_down = btn[3];
        ui.btn_mode = btn[4];
        ui.tick_1hz = tick;
    endtask

    task automatic apply_stimulus(input string step, input logic [4:0] btn,
                                  input logic tick, input exp_t e);
        @(negedge clk);
        drive(btn, tick);
        sb.push_back(e);
        @(posedge clk);
        #1;
        drive(B_NONE, 1'b0);
        check_output(step);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        drive(B_NONE, 1'b0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        sb.push_back(view_exp(3'd0));
        check_output("reset");
        @(negedge clk);
        rst_n = 1'b1;

        apply_stimulus("idle0",  B_NONE, 1'b0, view_exp(3'd0));
        apply_stimulus("mode1",  B_MODE, 1'b0, view_exp(3'd1));
        apply_stimulus("mode2",  B_MODE, 1'b0, view_exp(3'd2));
        apply_stimulus("mode0",  B_MODE, 1'b0, view_exp(3'd0));

        $display("[TB] clock view edit walk");
        apply_stimulus("clk_set",   B_SET,  1'b0, edit_exp(3'd0, 13'h004, 4'd2));
        apply_stimulus("clk_next1", B_NEXT, 1'b0, edit_exp(3'd0, 13'h002, 4'd1));
        apply_stimulus("clk_next2", B_NEXT, 1'b0, edit_exp(3'd0, 13'h001, 4'd0));
        apply_stimulus("clk_next3", B_NEXT, 1'b0, pulse(view_exp(3'd0), P_COMMIT));
        apply_stimulus("clk_idle",  B_NONE, 1'b0, view_exp(3'd0));

        $display("[TB] d-day edit inc/dec");
        apply_stimulus("dc_mode1", B_MODE, 1'b0, view_exp(3'd1));
        apply_stimulus("dc_mode2", B_MODE, 1'b0, view_exp(3'd2));
        apply_stimulus("dc_set",   B_SET,  1'b0, edit_exp(3'd2, 13'h1000, 4'd12));
        apply_stimulus("dc_up",    B_UP,   1'b0, pulse(edit_exp(3'd2, 13'h1000, 4'd12), P_INC));
        apply_stimulus("dc_idle1", B_NONE, 1'b0, edit_exp(3'd2, 13'h1000, 4'd12));
        apply_stimulus("dc_down",  B_DOWN, 1'b0, pulse(edit_exp(3'd2, 13'h1000, 4'd12), P_DEC));
        apply_stimulus("dc_modei", B_MODE, 1'b0, edit_exp(3'd2, 13'h1000, 4'd12));
        apply_stimulus("dc_exit",  B_SET,  1'b0, pulse(view_exp(3'd2), P_COMMIT));
        apply_stimulus("dc_idle2", B_NONE, 1'b0, view_exp(3'd2));

        $display("[TB] timeout");
        apply_stimulus("to_mode0", B_MODE, 1'b0, view_exp(3'd0));
        apply_stimulus("to_set",   B_SET,  1'b0, edit_exp(3'd0, 13'h004, 4'd2));
        apply_stimulus("to_tick1", B_NONE, 1'b1, edit_exp(3'd0, 13'h004, 4'd2));
        apply_stimulus("to_tick2", B_NONE, 1'b1, edit_exp(3'd0, 13'h004, 4'd2));
        apply_stimulus("to_tick3", B_NONE, 1'b1, pulse(view_exp(3'd0), P_ABORT));
        apply_stimulus("to_idle",  B_NONE, 1'b0, view_exp(3'd0));
        apply_stimulus("tb_set",   B_SET,  1'b0, edit_exp(3'd0, 13'h004, 4'd2));
        apply_stimulus("tb_tick1", B_NONE, 1'b1, edit_exp(3'd0, 13'h004, 4'd2));
        apply_stimulus("tb_tick2", B_NONE, 1'b1, edit_exp(3'd0, 13'h004, 4'd2));
        apply_stimulus("tb_uptk",  B_UP,   1'b1, pulse(edit_exp(3'd0, 13'h004, 4'd2), P_INC));
        apply_stimulus("tb_tick4", B_NONE, 1'b1, edit_exp(3'd0, 13'h004, 4'd2));
        apply_stimulus("tb_tick5", B_NONE, 1'b1, edit_exp(3'd0, 13'h004, 4'd2));
        apply_stimulus("tb_tick6", B_NONE, 1'b1, pulse(view_exp(3'd0), P_ABORT));
        apply_stimulus("tb_vtick", B_NONE, 1'b1, view_exp(3'd0));

        $display("[TB] priority and date field walk");
        apply_stimulus("pr_mode1",  B_MODE, 1'b0, view_exp(3'd1));
        apply_stimulus("pr_ignore", B_NEXT | B_UP | B_DOWN, 1'b0, view_exp(3'd1));
        apply_stimulus("pr_setup",  B_SET | B_UP, 1'b0, edit_exp(3'd1, 13'h080, 4'd7));
        apply_stimulus("pr_nxtdn",  B_NEXT | B_DOWN, 1'b0, edit_exp(3'd1, 13'h040, 4'd6));
        apply_stimulus("dt_next5",  B_NEXT, 1'b0, edit_exp(3'd1, 13'h020, 4'd5));
        apply_stimulus("dt_next4",  B_NEXT, 1'b0, edit_exp(3'd1, 13'h010, 4'd4));
        apply_stimulus("dt_next3",  B_NEXT, 1'b0, edit_exp(3'd1, 13'h008, 4'd3));
        apply_stimulus("dt_last",   B_NEXT, 1'b0, pulse(view_exp(3'd1), P_COMMIT));
        apply_stimulus("pr_setmd",  B_SET | B_MODE, 1'b0, edit_exp(3'd1, 13'h080, 4'd7));
        apply_stimulus("pr_exit",   B_SET, 1'b0, pulse(view_exp(3'd1), P_COMMIT));

        $display("[TB] asynchronous reset during edit");
        apply_stimulus("ar_mode2", B_MODE, 1'b0, view_exp(3'd2));
        apply_stimulus("ar_set",   B_SET,  1'b0, edit_exp(3'd2, 13'h1000, 4'd12));
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        sb.push_back(view_exp(3'd0));
        check_output("ar_async");
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus("ar_idle1", B_NONE, 1'b0, view_exp(3'd0));
        apply_stimulus("ar_tick1", B_NONE, 1'b1, view_exp(3'd0));
        apply_stimulus("ar_tick2", B_NONE, 1'b1, view_exp(3'd0));
        apply_stimulus("ar_tick3", B_NONE, 1'b1, view_exp(3'd0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
